// File: rtl/prio_cond_pkg.sv
`default_nettype none
// ============================================================================
// prio_cond_pkg : shared defaults and counter sizing for the input conditioner
// Revision      : 1.0
// ============================================================================
package prio_cond_pkg;

  localparam int unsigned C_WIDTH    = 8;
  localparam int unsigned C_PRESCALE = 1000;
  localparam int unsigned C_DB_COUNT = 4;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// debounce_bit : two-flop sync, tick-sampled counter debounce, rise pulse
// Revision     : 1.0
// ============================================================================
module debounce_bit
  import prio_cond_pkg::*;
#(
  parameter int unsigned DB_COUNT = C_DB_COUNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned    CW     = cnt_width(DB_COUNT);
  localparam logic [CW-1:0]  C_LAST = CW'(DB_COUNT - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The rise pulse lags the level by one cycle so it sits just after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule
`default_nettype wire

// File: rtl/priority_input_conditioner.sv
`default_nettype none
// ============================================================================
// priority_input_conditioner : debounced / sticky input word for the encoder
// Revision                   : 1.0
// ============================================================================
module priority_input_conditioner
  import prio_cond_pkg::*;
#(
  parameter int unsigned WIDTH    = C_WIDTH,
  parameter int unsigned PRESCALE = C_PRESCALE,
  parameter int unsigned DB_COUNT = C_DB_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             sticky_en,
  input  logic             clear,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] rise,
  output logic             tick
);

  localparam int unsigned   PW      = cnt_width(PRESCALE);
  localparam logic [PW-1:0] C_PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pcnt_q;
  logic [PW-1:0]    pcnt_d;
  logic             tick_q;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_bits;
  logic [WIDTH-1:0] hold_q;

  always_comb begin
    pcnt_d = (pcnt_q == C_PLAST) ? '0 : pcnt_q + 1'b1;
  end

  // tick is registered against the next count so it is high exactly while pcnt==PRESCALE-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= (pcnt_d == C_PLAST);
      hold_q <= (hold_q & ~{WIDTH{clear}}) | rise_bits;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_COUNT (DB_COUNT)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw_in[i]),
      .tick_i  (tick_q),
      .level_o (level[i]),
      .rise_o  (rise_bits[i])
    );
  end

  assign data = sticky_en ? hold_q : level;
  assign rise = rise_bits;
  assign tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_priority_input_conditioner : directed + random bench with reference model
// Revision                      : 1.0
// ============================================================================
module tb_priority_input_conditioner;

  localparam int W  = 8;
  localparam int P  = 4;
  localparam int DB = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic         sticky_en = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] data;
  logic [W-1:0] rise;
  logic         tick;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  priority_input_conditioner #(
    .WIDTH    (W),
    .PRESCALE (P),
    .DB_COUNT (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (raw_in),
    .sticky_en (sticky_en),
    .clear     (clear),
    .data      (data),
    .rise      (rise),
    .tick      (tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: edges since release decide ticks; each bit tracks its run of
  // consecutive mismatching ticks and flips once the run reaches DB.
  logic [W-1:0] q_raw[$];
  logic [W-1:0] m_s, m_sprev, m_rise, m_hold;
  int           m_run[W];
  int           m_k;
  logic         m_tick;

  task automatic model_reset();
    q_raw = '{'0, '0};
    m_s = '0; m_sprev = '0; m_rise = '0; m_hold = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_k = 0;
    m_tick = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] sync, s_old, rise_old;
    sync     = q_raw[0];
    s_old    = m_s;
    rise_old = m_rise;
    q_raw.push_back(raw_in);
    q_raw.delete(0);
    if (m_tick) begin
      for (int i = 0; i < W; i++) begin
        if (sync[i] == m_s[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_s[i] = sync[i];
            m_run[i] = 0;
          end
        end
      end
    end
    m_rise  = s_old & ~m_sprev;
    m_sprev = s_old;
    m_hold  = (m_hold & ~{W{clear}}) | rise_old;
    m_k++;
    m_tick  = ((m_k % P) == P - 1);
  endtask

  function automatic logic [W-1:0] exp_data();
    return sticky_en ? m_hold : m_s;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    chk("data", data, exp_data());
    chk("rise", rise, m_rise);
    chk("tick", tick, m_tick);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  int n;
  logic [W-1:0] acc;

  initial begin
    // Reset with all inputs high
    model_reset();
    rst_n  = 1'b0;
    raw_in = 8'hFF;
    #1;
    chk("rst_data_async", data, 0);
    steps(10);
    raw_in = 8'h00;
    rst_n  = 1'b1;
    n = 0;
    while (!tick && n < 20) begin step(); n++; end
    chk("first_tick_cycle", n, 3);
    steps(3);
    chk("tick_gap", tick, 0);
    step();
    chk("tick_period", tick, 1);
    steps(12);

    // Clean step: latency window then a single rise pulse
    raw_in = 8'h20;
    n = 0;
    do begin step(); n++; end while (data != 8'h20 && n < 40);
    chk("step_latency_ok", (n >= 11 && n <= 14), 1);
    chk("step_rise_same", rise, 0);
    step();
    chk("step_rise_pulse", rise, 8'h20);
    step();
    chk("step_rise_end", rise, 0);

    // Glitch rejection, then a long pulse
    raw_in = 8'h28;
    steps(6);
    raw_in = 8'h20;
    steps(20);
    chk("glitch_data", data, 8'h20);
    raw_in = 8'h28;
    steps(16);
    chk("long_data", data, 8'h28);

    // Release produces no rise
    raw_in = 8'h81;
    steps(16);
    chk("set81_data", data, 8'h81);
    raw_in = 8'h01;
    acc = '0;
    for (int i = 0; i < 16; i++) begin step(); acc |= rise; end
    chk("release_rise", acc, 0);
    chk("release_data", data, 8'h01);

    // Sticky capture and clear
    raw_in = 8'h00;
    steps(16);
    clear = 1'b1; step(); clear = 1'b0;
    sticky_en = 1'b1;
    #1;
    chk("sticky_empty", data, 0);
    raw_in = 8'h40; steps(16);
    raw_in = 8'h00; steps(16);
    raw_in = 8'h04; steps(16);
    raw_in = 8'h00; steps(16);
    chk("sticky_hold", data, 8'h44);
    sticky_en = 1'b0;
    #1;
    chk("sticky_live", data, 0);
    sticky_en = 1'b1;
    clear = 1'b1; step(); clear = 1'b0;
    chk("sticky_clear", data, 0);

    // Clear coinciding with rise[7]
    raw_in = 8'h02; steps(16);
    chk("pre_collide", data, 8'h02);
    raw_in = 8'h82;
    n = 0;
    while (!m_rise[7] && n < 40) begin step(); n++; end
    chk("collide_found", m_rise[7], 1);
    clear = 1'b1; step(); clear = 1'b0;
    step();
    chk("collide_hold", data, 8'h80);

    // Reset in the middle of a debounce count
    sticky_en = 1'b0;
    raw_in = 8'h92;
    steps(9);
    chk("partial_no_change", data, 8'h82);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_tick", tick, 0);
    steps(3);
    rst_n = 1'b1;
    n = 0;
    while (!data[4] && n < 40) begin step(); n++; end
    chk("midrst_full_latency", n, 12);

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      raw_in    = W'($urandom);
      sticky_en = 1'($urandom_range(0, 1));
      for (int c = 0, len = $urandom_range(1, 20); c < len; c++) begin
        clear = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 5) == 0) raw_in ^= W'(1 << $urandom_range(0, W - 1));
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 1'b0;
          model_reset();
          #1;
          chk("rand_rst", {data, rise, 7'd0, tick}, 0);
          steps(2);
          rst_n = 1'b1;
        end
        step();
      end
      clear = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
